// File: rtl/c_stage_if.sv
// c_stage_if: request/acknowledge data-memory port of the C (memory-access)
// stage.
//   dmem_req   : request active; held high until ack or timeout
//   dmem_we    : 1 = store (write), 0 = load (read)
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : store data
//   dmem_ack   : memory completion
//   dmem_rdata : load data, valid together with dmem_ack
// The master modport is used by the pipeline stage; the slave modport by the
// memory.
interface c_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/c_stage.sv
// c_stage: memory-access stage of the 32-bit RISC-V pipeline.
// Takes one instruction from the execute stage when a_ready is high and
// c_ready allows it. ALU ops and misaligned load/store finish in one cycle.
// Aligned word loads/stores go out on the dmem port and wait for dmem_ack,
// bounded by TIMEOUT_CYCLES request cycles.
// Ports:
//   clock, reset          : clock, synchronous active-high reset
//   a_ready, ac_*         : instruction from the execute stage
//   ALU_result            : ALU result / effective address
//   ac_store_data         : store data (rs2)
//   c_ready               : combinational accept signal to the execute stage
//   dmem                  : data-memory port (c_stage_if.master)
//   cw_valid              : one-cycle pulse, writeback payload valid
//   cw_pc, cw_write_sel, cw_is_wb, cw_data : writeback payload (held)
//   cw_misaligned, cw_bus_err              : exception flags, qualified by cw_valid
module c_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a_ready,
  input  logic [31:0]      ac_pc,
  input  logic [4:0]       ac_write_sel,
  input  logic             ac_is_load,
  input  logic             ac_is_store,
  input  logic             ac_is_wb,
  input  logic [31:0]      ALU_result,
  input  logic [31:0]      ac_store_data,
  output logic             c_ready,
  c_stage_if.master        dmem,
  output logic             cw_valid,
  output logic [31:0]      cw_pc,
  output logic [4:0]       cw_write_sel,
  output logic             cw_is_wb,
  output logic [31:0]      cw_data,
  output logic             cw_misaligned,
  output logic             cw_bus_err
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT_CYCLES);
  // Counter value in the last allowed request cycle.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_MEM = 1'b1} state_e;

  state_e state_q, state_d;

  logic [31:0]   pc_q, pc_d;
  logic [4:0]    sel_q, sel_d;
  logic          is_wb_q, is_wb_d;
  logic          is_load_q, is_load_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          dmem_req_q, dmem_req_d;
  logic          dmem_we_q, dmem_we_d;
  logic [31:0]   dmem_addr_q, dmem_addr_d;
  logic [31:0]   dmem_wdata_q, dmem_wdata_d;

  logic          cw_valid_q, cw_valid_d;
  logic [31:0]   cw_pc_q, cw_pc_d;
  logic [4:0]    cw_write_sel_q, cw_write_sel_d;
  logic          cw_is_wb_q, cw_is_wb_d;
  logic [31:0]   cw_data_q, cw_data_d;
  logic          cw_misaligned_q, cw_misaligned_d;
  logic          cw_bus_err_q, cw_bus_err_d;

  logic is_mem_s, aligned_s, start_mem_s, timeout_s;

  assign is_mem_s    = ac_is_load | ac_is_store;
  assign aligned_s   = (ALU_result[1:0] == 2'b00);
  assign start_mem_s = a_ready & is_mem_s & aligned_s;
  // Ack in the last allowed cycle takes priority over the timeout.
  assign timeout_s   = (state_q == S_MEM) & ~dmem.dmem_ack & (cnt_q == CNT_LAST);

  assign c_ready = ~reset & (state_q == S_IDLE) & ~start_mem_s;

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_mem_s) state_d = S_MEM;
        else             state_d = S_IDLE;
      end
      S_MEM: begin
        if (dmem.dmem_ack || timeout_s) state_d = S_IDLE;
        else                            state_d = S_MEM;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values.
  always_comb begin
    pc_d            = pc_q;
    sel_d           = sel_q;
    is_wb_d         = is_wb_q;
    is_load_d       = is_load_q;
    cnt_d           = cnt_q;
    dmem_req_d      = dmem_req_q;
    dmem_we_d       = dmem_we_q;
    dmem_addr_d     = dmem_addr_q;
    dmem_wdata_d    = dmem_wdata_q;
    cw_valid_d      = 1'b0;
    cw_pc_d         = cw_pc_q;
    cw_write_sel_d  = cw_write_sel_q;
    cw_is_wb_d      = cw_is_wb_q;
    cw_data_d       = cw_data_q;
    cw_misaligned_d = cw_misaligned_q;
    cw_bus_err_d    = cw_bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (start_mem_s) begin
          pc_d         = ac_pc;
          sel_d        = ac_write_sel;
          is_wb_d      = ac_is_wb;
          is_load_d    = ac_is_load;
          cnt_d        = '0;
          dmem_req_d   = 1'b1;
          dmem_we_d    = ac_is_store & ~ac_is_load;
          dmem_addr_d  = ALU_result;
          dmem_wdata_d = ac_store_data;
        end else if (a_ready) begin
          // ALU op, or a misaligned load/store that never reaches memory.
          cw_valid_d      = 1'b1;
          cw_pc_d         = ac_pc;
          cw_write_sel_d  = ac_write_sel;
          cw_data_d       = ALU_result;
          cw_is_wb_d      = ac_is_wb & ~is_mem_s;
          cw_misaligned_d = is_mem_s;
          cw_bus_err_d    = 1'b0;
        end else begin
          cw_valid_d = 1'b0;
        end
      end
      S_MEM: begin
        // Saturating count of request cycles.
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
        else                  cnt_d = cnt_q;
        if (dmem.dmem_ack) begin
          dmem_req_d      = 1'b0;
          cw_valid_d      = 1'b1;
          cw_pc_d         = pc_q;
          cw_write_sel_d  = sel_q;
          cw_data_d       = is_load_q ? dmem.dmem_rdata : dmem_addr_q;
          cw_is_wb_d      = is_wb_q;
          cw_misaligned_d = 1'b0;
          cw_bus_err_d    = 1'b0;
        end else if (timeout_s) begin
          dmem_req_d      = 1'b0;
          cw_valid_d      = 1'b1;
          cw_pc_d         = pc_q;
          cw_write_sel_d  = sel_q;
          cw_data_d       = dmem_addr_q;
          cw_is_wb_d      = 1'b0;
          cw_misaligned_d = 1'b0;
          cw_bus_err_d    = 1'b1;
        end else begin
          dmem_req_d = 1'b1;
        end
      end
      default: begin
        dmem_req_d = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q            <= 32'h0;
      sel_q           <= 5'h0;
      is_wb_q         <= 1'b0;
      is_load_q       <= 1'b0;
      cnt_q           <= '0;
      dmem_req_q      <= 1'b0;
      dmem_we_q       <= 1'b0;
      dmem_addr_q     <= 32'h0;
      dmem_wdata_q    <= 32'h0;
      cw_valid_q      <= 1'b0;
      cw_pc_q         <= 32'h0;
      cw_write_sel_q  <= 5'h0;
      cw_is_wb_q      <= 1'b0;
      cw_data_q       <= 32'h0;
      cw_misaligned_q <= 1'b0;
      cw_bus_err_q    <= 1'b0;
    end else begin
      pc_q            <= pc_d;
      sel_q           <= sel_d;
      is_wb_q         <= is_wb_d;
      is_load_q       <= is_load_d;
      cnt_q           <= cnt_d;
      dmem_req_q      <= dmem_req_d;
      dmem_we_q       <= dmem_we_d;
      dmem_addr_q     <= dmem_addr_d;
      dmem_wdata_q    <= dmem_wdata_d;
      cw_valid_q      <= cw_valid_d;
      cw_pc_q         <= cw_pc_d;
      cw_write_sel_q  <= cw_write_sel_d;
      cw_is_wb_q      <= cw_is_wb_d;
      cw_data_q       <= cw_data_d;
      cw_misaligned_q <= cw_misaligned_d;
      cw_bus_err_q    <= cw_bus_err_d;
    end
  end

  assign dmem.dmem_req   = dmem_req_q;
  assign dmem.dmem_we    = dmem_we_q;
  assign dmem.dmem_addr  = dmem_addr_q;
  assign dmem.dmem_wdata = dmem_wdata_q;
  assign cw_valid        = cw_valid_q;
  assign cw_pc           = cw_pc_q;
  assign cw_write_sel    = cw_write_sel_q;
  assign cw_is_wb        = cw_is_wb_q;
  assign cw_data         = cw_data_q;
  assign cw_misaligned   = cw_misaligned_q;
  assign cw_bus_err      = cw_bus_err_q;

endmodule

// File: tb/tb_c_stage.sv
// tb_c_stage: directed self-checking bench for c_stage (TIMEOUT_CYCLES = 4).
// Inputs change 1 time unit after the rising edge; outputs are read there too.
module tb_c_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        a_ready;
  logic [31:0] ac_pc;
  logic [4:0]  ac_write_sel;
  logic        ac_is_load, ac_is_store, ac_is_wb;
  logic [31:0] ALU_result, ac_store_data;
  logic        c_ready;
  logic        cw_valid;
  logic [31:0] cw_pc;
  logic [4:0]  cw_write_sel;
  logic        cw_is_wb;
  logic [31:0] cw_data;
  logic        cw_misaligned, cw_bus_err;

  int checks = 0;
  int errors = 0;

  c_stage_if dif ();

  c_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .a_ready(a_ready), .ac_pc(ac_pc),
    .ac_write_sel(ac_write_sel), .ac_is_load(ac_is_load), .ac_is_store(ac_is_store),
    .ac_is_wb(ac_is_wb), .ALU_result(ALU_result), .ac_store_data(ac_store_data),
    .c_ready(c_ready), .dmem(dif), .cw_valid(cw_valid), .cw_pc(cw_pc),
    .cw_write_sel(cw_write_sel), .cw_is_wb(cw_is_wb), .cw_data(cw_data),
    .cw_misaligned(cw_misaligned), .cw_bus_err(cw_bus_err)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    a_ready = 1'b0; ac_is_load = 1'b0; ac_is_store = 1'b0; ac_is_wb = 1'b0;
  endtask

  task automatic drive_op(input logic ld, input logic st, input logic wb,
                          input logic [31:0] addr, input logic [31:0] sd,
                          input logic [31:0] pc, input logic [4:0] sel);
    a_ready = 1'b1; ac_is_load = ld; ac_is_store = st; ac_is_wb = wb;
    ALU_result = addr; ac_store_data = sd; ac_pc = pc; ac_write_sel = sel;
  endtask

  task automatic test_reset();
    reset = 1'b1; drive_idle();
    ALU_result = 32'h0; ac_store_data = 32'h0; ac_pc = 32'h0; ac_write_sel = 5'd0;
    dif.dmem_ack = 1'b0; dif.dmem_rdata = 32'h0;
    step(); step();
    checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL rst_c_ready got %0b exp 0", c_ready); end
    checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0b exp 0", dif.dmem_req); end
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL rst_cw_valid got %0b exp 0", cw_valid); end
    checks++; if (cw_data !== 32'h0) begin errors++; $display("FAIL rst_cw_data got %h exp 0", cw_data); end
    checks++; if (dif.dmem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", dif.dmem_addr); end
    reset = 1'b0;
    #1;
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL rst_release_c_ready got %0b exp 1", c_ready); end
  endtask

  task automatic test_alu();
    logic [31:0] exp_data [3];
    exp_data[0] = 32'h10; exp_data[1] = 32'h20; exp_data[2] = 32'h30;
    for (int i = 0; i < 3; i++) begin
      drive_op(1'b0, 1'b0, 1'b1, exp_data[i], 32'h0, 32'h1000 + 32'(i * 4), 5'(i + 1));
      #1;
      checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL alu_c_ready[%0d] got %0b exp 1", i, c_ready); end
      step();
      checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL alu_valid[%0d] got %0b exp 1", i, cw_valid); end
      checks++; if (cw_data !== exp_data[i]) begin errors++; $display("FAIL alu_data[%0d] got %h exp %h", i, cw_data, exp_data[i]); end
      checks++; if (cw_write_sel !== 5'(i + 1)) begin errors++; $display("FAIL alu_sel[%0d] got %0d exp %0d", i, cw_write_sel, i + 1); end
      checks++; if (cw_is_wb !== 1'b1 || cw_misaligned !== 1'b0) begin errors++; $display("FAIL alu_flags[%0d] got wb=%0b mis=%0b exp wb=1 mis=0", i, cw_is_wb, cw_misaligned); end
    end
    drive_idle();
    step();
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL alu_pulse got %0b exp 0", cw_valid); end
    checks++; if (cw_data !== 32'h30) begin errors++; $display("FAIL alu_hold got %h exp 30", cw_data); end
  endtask

  task automatic test_load();
    drive_op(1'b1, 1'b0, 1'b1, 32'h100, 32'h0, 32'h2000, 5'd5);
    #1;
    checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL ld_c_ready_t got %0b exp 0", c_ready); end
    step();
    drive_idle();
    for (int r = 0; r < 4; r++) begin
      if (r == 3) begin dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hDEADBEEF; end
      #1;
      checks++; if (dif.dmem_req !== 1'b1) begin errors++; $display("FAIL ld_req[%0d] got %0b exp 1", r, dif.dmem_req); end
      checks++; if (c_ready !== 1'b0) begin errors++; $display("FAIL ld_c_ready[%0d] got %0b exp 0", r, c_ready); end
      checks++; if (dif.dmem_we !== 1'b0 || dif.dmem_addr !== 32'h100) begin errors++; $display("FAIL ld_bus[%0d] got we=%0b addr=%h exp we=0 addr=100", r, dif.dmem_we, dif.dmem_addr); end
      step();
    end
    dif.dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b1) begin errors++; $display("FAIL ld_valid got %0b exp 1", cw_valid); end
    checks++; if (cw_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_data got %h exp deadbeef", cw_data); end
    checks++; if (cw_is_wb !== 1'b1 || cw_bus_err !== 1'b0) begin errors++; $display("FAIL ld_flags got wb=%0b err=%0b exp wb=1 err=0", cw_is_wb, cw_bus_err); end
    checks++; if (cw_pc !== 32'h2000 || cw_write_sel !== 5'd5) begin errors++; $display("FAIL ld_payload got pc=%h sel=%0d exp pc=2000 sel=5", cw_pc, cw_write_sel); end
    checks++; if (dif.dmem_req !== 1'b0 || c_ready !== 1'b1) begin errors++; $display("FAIL ld_done got req=%0b rdy=%0b exp req=0 rdy=1", dif.dmem_req, c_ready); end
  endtask

  task automatic test_store();
    drive_op(1'b0, 1'b1, 1'b0, 32'h204, 32'h12345678, 32'h3000, 5'd0);
    step();
    drive_idle();
    checks++; if (dif.dmem_req !== 1'b1 || dif.dmem_we !== 1'b1) begin errors++; $display("FAIL st_req got req=%0b we=%0b exp 1 1", dif.dmem_req, dif.dmem_we); end
    checks++; if (dif.dmem_wdata !== 32'h12345678 || dif.dmem_addr !== 32'h204) begin errors++; $display("FAIL st_bus got wdata=%h addr=%h exp 12345678 204", dif.dmem_wdata, dif.dmem_addr); end
    dif.dmem_ack = 1'b1;
    step();
    dif.dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b1 || cw_bus_err !== 1'b0) begin errors++; $display("FAIL st_done got valid=%0b err=%0b exp 1 0", cw_valid, cw_bus_err); end
    checks++; if (cw_data !== 32'h204) begin errors++; $display("FAIL st_data got %h exp 204", cw_data); end
    checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL st_req_drop got %0b exp 0", dif.dmem_req); end
  endtask

  task automatic test_misaligned();
    drive_op(1'b1, 1'b0, 1'b1, 32'h102, 32'h0, 32'h4000, 5'd7);
    #1;
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL mis_c_ready got %0b exp 1", c_ready); end
    step();
    drive_idle();
    checks++; if (dif.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %0b exp 0", dif.dmem_req); end
    checks++; if (cw_valid !== 1'b1 || cw_misaligned !== 1'b1) begin errors++; $display("FAIL mis_flag got valid=%0b mis=%0b exp 1 1", cw_valid, cw_misaligned); end
    checks++; if (cw_is_wb !== 1'b0 || cw_data !== 32'h102) begin errors++; $display("FAIL mis_payload got wb=%0b data=%h exp 0 102", cw_is_wb, cw_data); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL mis_c_ready_after got %0b exp 1", c_ready); end
    step();
    checks++; if (cw_valid !== 1'b0 || dif.dmem_req !== 1'b0) begin errors++; $display("FAIL mis_quiet got valid=%0b req=%0b exp 0 0", cw_valid, dif.dmem_req); end
  endtask

  task automatic test_timeout();
    int n;
    n = 0;
    drive_op(1'b1, 1'b0, 1'b1, 32'h300, 32'h0, 32'h5000, 5'd9);
    step();
    drive_idle();
    for (int i = 0; i < 10; i++) begin
      if (dif.dmem_req === 1'b1) begin n++; step(); end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL to_req_cycles got %0d exp 4", n); end
    checks++; if (cw_valid !== 1'b1 || cw_bus_err !== 1'b1) begin errors++; $display("FAIL to_err got valid=%0b err=%0b exp 1 1", cw_valid, cw_bus_err); end
    checks++; if (cw_is_wb !== 1'b0) begin errors++; $display("FAIL to_is_wb got %0b exp 0", cw_is_wb); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL to_c_ready got %0b exp 1", c_ready); end
    step();
    checks++; if (cw_valid !== 1'b0) begin errors++; $display("FAIL to_pulse got %0b exp 0", cw_valid); end
  endtask

  task automatic test_timeout_ack();
    drive_op(1'b1, 1'b0, 1'b1, 32'h304, 32'h0, 32'h5100, 5'd10);
    step();
    drive_idle();
    step(); step(); step();
    checks++; if (dif.dmem_req !== 1'b1) begin errors++; $display("FAIL toa_req4 got %0b exp 1", dif.dmem_req); end
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'hCAFEF00D;
    step();
    dif.dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b1 || cw_bus_err !== 1'b0) begin errors++; $display("FAIL toa_done got valid=%0b err=%0b exp 1 0", cw_valid, cw_bus_err); end
    checks++; if (cw_data !== 32'hCAFEF00D || cw_is_wb !== 1'b1) begin errors++; $display("FAIL toa_data got data=%h wb=%0b exp cafef00d 1", cw_data, cw_is_wb); end
  endtask

  task automatic test_reset_mid();
    drive_op(1'b0, 1'b1, 1'b1, 32'h400, 32'hA5A5A5A5, 32'h6000, 5'd3);
    step();
    drive_idle();
    checks++; if (dif.dmem_req !== 1'b1) begin errors++; $display("FAIL rm_req got %0b exp 1", dif.dmem_req); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checks++; if (dif.dmem_req !== 1'b0 || dif.dmem_we !== 1'b0 || dif.dmem_addr !== 32'h0 || dif.dmem_wdata !== 32'h0) begin errors++; $display("FAIL rm_bus got req=%0b we=%0b addr=%h wdata=%h exp all 0", dif.dmem_req, dif.dmem_we, dif.dmem_addr, dif.dmem_wdata); end
    checks++; if (cw_data !== 32'h0 || cw_pc !== 32'h0 || cw_write_sel !== 5'd0 || cw_is_wb !== 1'b0) begin errors++; $display("FAIL rm_cw got data=%h pc=%h sel=%0d wb=%0b exp all 0", cw_data, cw_pc, cw_write_sel, cw_is_wb); end
    checks++; if (c_ready !== 1'b1) begin errors++; $display("FAIL rm_c_ready got %0b exp 1", c_ready); end
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h55;
    step();
    dif.dmem_ack = 1'b0;
    checks++; if (cw_valid !== 1'b0 || dif.dmem_req !== 1'b0 || cw_data !== 32'h0) begin errors++; $display("FAIL rm_ack_ignored got valid=%0b req=%0b data=%h exp 0 0 0", cw_valid, dif.dmem_req, cw_data); end
  endtask

  task automatic test_back_to_back();
    // ALU op right after a memory completion (earliest allowed slot).
    drive_op(1'b1, 1'b0, 1'b1, 32'h500, 32'h0, 32'h7000, 5'd4);
    step();
    drive_idle();
    dif.dmem_ack = 1'b1; dif.dmem_rdata = 32'h11112222;
    step();
    dif.dmem_ack = 1'b0;
    drive_op(1'b0, 1'b0, 1'b1, 32'h77, 32'h0, 32'h7004, 5'd6);
    #1;
    checks++; if (c_ready !== 1'b1 || cw_data !== 32'h11112222) begin errors++; $display("FAIL b2b_first got rdy=%0b data=%h exp 1 11112222", c_ready, cw_data); end
    step();
    drive_idle();
    checks++; if (cw_valid !== 1'b1 || cw_data !== 32'h77 || cw_write_sel !== 5'd6) begin errors++; $display("FAIL b2b_second got valid=%0b data=%h sel=%0d exp 1 77 6", cw_valid, cw_data, cw_write_sel); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misaligned();
    test_timeout();
    test_timeout_ack();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
